// File: rtl/data_array_pkg.sv
// Shared constants and response-entry layout for the banked data array.
// Optional feature macro: DATA_ARRAY_PARITY_EN (one even-parity bit stored per byte lane).
package data_array_pkg;

    localparam int DA_ADDR_W = 9;
    localparam int DA_BYTES  = 16;
    localparam int DA_BANKS  = 2;
    localparam int LANE_W    = 8;

`ifdef DATA_ARRAY_PARITY_EN
    localparam int STORE_LANE_W = LANE_W + 1;
`else
    localparam int STORE_LANE_W = LANE_W;
`endif

    // Response FIFO entry; its width follows DA_BYTES, so the controller's BYTES must match it.
    typedef struct packed {
        logic [DA_BYTES*LANE_W-1:0] rdata;
        logic [DA_BYTES-1:0]        perr;
    } resp_entry_t;

endpackage

// File: rtl/data_array_bank.sv
// Single-port SRAM bank with per-lane write mask; read data is valid one cycle after en.
// Lane storage width is a parameter so the controller can append a parity bit per lane.
module data_array_bank #(
    parameter int ROW_W  = 8,
    parameter int BYTES  = 16,
    parameter int LANE_W = 8
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    wmode,
    input  logic [ROW_W-1:0]        addr,
    input  logic [BYTES*LANE_W-1:0] wdata,
    input  logic [BYTES-1:0]        wmask,
    output logic [BYTES*LANE_W-1:0] rdata
);

    localparam int ROWS = 1 << ROW_W;

    logic [BYTES*LANE_W-1:0] mem [ROWS];

    // NOTE: the array models an SRAM macro, so neither contents nor the read register are reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (wmode) begin
                for (int i = 0; i < BYTES; i++) begin
                    if (wmask[i]) begin
                        mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_array_bank_ctrl.sv
// Banked data-array controller: one request per cycle, reads return in order via a 2-entry FIFO.
// Optional feature macro: DATA_ARRAY_PARITY_EN (per-lane parity storage and resp_perr reporting).
module data_array_bank_ctrl
    import data_array_pkg::*;
#(
    parameter int ADDR_W = DA_ADDR_W,
    parameter int BYTES  = DA_BYTES,
    parameter int BANKS  = DA_BANKS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [8*BYTES-1:0]      req_wdata,
    input  logic [BYTES-1:0]        req_wmask,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [8*BYTES-1:0]      resp_rdata,
    output logic [BYTES-1:0]        resp_perr
);

    localparam int SLW       = STORE_LANE_W;
    localparam int SW        = BYTES * SLW;
    localparam int BANK_BITS = $clog2(BANKS);
    localparam int SEL_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROW_W     = ADDR_W - BANK_BITS;

    logic               active;
    logic [1:0]         credits;
    logic               inflight;
    logic [SEL_W-1:0]   inflight_bank;
    logic [SEL_W-1:0]   bank_sel;
    logic [BANKS-1:0]   bank_en;
    logic [SW-1:0]      store_wdata;
    logic [SW-1:0]      bank_rdata [BANKS];
    logic [SW-1:0]      sram_rdata;
    resp_entry_t        fifo [2];
    resp_entry_t        push_entry;
    logic               wr_ptr, rd_ptr;
    logic [1:0]         count;
    logic               accept, rd_accept, pop;

    // Writes never need a credit; a read is refused only when both response slots are spoken for.
    assign req_ready = active && (req_write || credits != 2'd2);
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_write;
    assign pop       = resp_valid && resp_ready;

    assign resp_valid = (count != 2'd0);
    assign resp_rdata = fifo[rd_ptr].rdata;
    assign resp_perr  = fifo[rd_ptr].perr;

    if (BANKS > 1) begin : g_sel
        assign bank_sel = req_addr[BANK_BITS-1:0];
    end else begin : g_nosel
        assign bank_sel = '0;
    end

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        store_wdata = '0;
        for (int i = 0; i < BYTES; i++) begin
            store_wdata[i*SLW +: LANE_W] = req_wdata[i*LANE_W +: LANE_W];
`ifdef DATA_ARRAY_PARITY_EN
            store_wdata[i*SLW + LANE_W]  = ^req_wdata[i*LANE_W +: LANE_W];
`endif
        end
    end

    always_comb begin
        bank_en = '0;
        for (int b = 0; b < BANKS; b++) begin
            bank_en[b] = accept && (bank_sel == SEL_W'(b));
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        data_array_bank #(
            .ROW_W  (ROW_W),
            .BYTES  (BYTES),
            .LANE_W (SLW)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en[b]),
            .wmode (req_write),
            .addr  (req_addr[ADDR_W-1:BANK_BITS]),
            .wdata (store_wdata),
            .wmask (req_wmask),
            .rdata (bank_rdata[b])
        );
    end

    assign sram_rdata = bank_rdata[inflight_bank];

    // Even parity over data plus stored parity bit is zero for an intact lane.
    always_comb begin
        push_entry = '0;
        for (int i = 0; i < BYTES; i++) begin
            push_entry.rdata[i*LANE_W +: LANE_W] = sram_rdata[i*SLW +: LANE_W];
`ifdef DATA_ARRAY_PARITY_EN
            push_entry.perr[i] = ^sram_rdata[i*SLW +: SLW];
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active        <= 1'b0;
            credits       <= 2'd0;
            inflight      <= 1'b0;
            inflight_bank <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo[i] <= '0;
            end
        end else begin
            active   <= 1'b1;
            inflight <= rd_accept;
            if (rd_accept) begin
                inflight_bank <= bank_sel;
            end
            if (inflight) begin
                fifo[wr_ptr] <= push_entry;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count   <= count + 2'(inflight) - 2'(pop);
            credits <= credits + 2'(rd_accept) - 2'(pop);
        end
    end

endmodule
